// File: rtl/im_load_ctrl.sv
// Instruction-memory loader: streams up to 16 words into IM, then releases the core (optional IM_LOAD_CHECKSUM_EN trailer check).
// One registered write cycle per accepted word; in_ready low outside LOAD/CHECK, and in_valid=0 stalls the load indefinitely.
module im_load_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  load_count,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic [31:0] fetch_pc,
    output logic [31:0] im_addr,
    output logic [31:0] im_dataIn,
    output logic        im_memWrite,
    output logic        im_memRead,
    output logic        core_run,
    output logic        busy,
    output logic [4:0]  words_loaded,
    output logic        csum_err
);

`ifdef IM_LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_CHECK, S_RUN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN} state_t;
`endif

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  words_q, words_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic        xfer;
`ifdef IM_LOAD_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic        err_q, err_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            words_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
`ifdef IM_LOAD_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
`ifdef IM_LOAD_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

`ifdef IM_LOAD_CHECKSUM_EN
    assign in_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign busy     = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_CHECK);
    assign csum_err = err_q;
`else
    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign csum_err = 1'b0;
`endif

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        idx_d   = idx_q;
        data_d  = data_q;
        wr_d    = 1'b0;
`ifdef IM_LOAD_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE, S_RUN: begin
                if (start) begin
                    cnt_d   = load_count;
                    words_d = '0;
`ifdef IM_LOAD_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                    state_d = (load_count == 5'd0) ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    // Registered so the write is stable across the memory's capturing falling edge.
                    wr_d    = 1'b1;
                    data_d  = in_data;
                    idx_d   = words_q[3:0];
                    words_d = words_q + 5'd1;
`ifdef IM_LOAD_CHECKSUM_EN
                    sum_d   = sum_q + in_data;
`endif
                    if (words_q + 5'd1 == cnt_q) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
`ifdef IM_LOAD_CHECKSUM_EN
                state_d = S_CHECK;
`else
                state_d = S_RUN;
`endif
            end
`ifdef IM_LOAD_CHECKSUM_EN
            S_CHECK: begin
                // Trailer word is compared only, never written.
                if (xfer) begin
                    if (in_data == sum_q) begin
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign core_run     = (state_q == S_RUN);
    assign im_memRead   = core_run;
    assign im_memWrite  = wr_q;
    assign im_dataIn    = data_q;
    assign words_loaded = words_q;
    assign im_addr      = (core_run && !wr_q) ? fetch_pc : {26'd0, idx_q, 2'b00};

endmodule

// File: tb/tb_im_load_ctrl.sv
// Bench for im_load_ctrl: directed sequences, a vector table and randomized loads against a transfer-counting model.
module tb_im_load_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready;
    logic [4:0]  load_count, words_loaded;
    logic [31:0] in_data, fetch_pc, im_addr, im_dataIn;
    logic        im_memWrite, im_memRead, core_run, busy, csum_err;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_total = 0;
    logic [31:0] last_addr = '0;

    im_load_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .load_count(load_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .fetch_pc(fetch_pc), .im_addr(im_addr), .im_dataIn(im_dataIn),
        .im_memWrite(im_memWrite), .im_memRead(im_memRead), .core_run(core_run),
        .busy(busy), .words_loaded(words_loaded), .csum_err(csum_err)
    );

    always #5 clk = ~clk;

    // Reference model: the n-th accepted word of a load goes to address (n mod 16)*4 in the next cycle.
    logic [4:0]  m_cnt, m_done;
    logic [31:0] m_sum, exp_addr, exp_data;
    logic        exp_wr;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt <= '0; m_done <= '0; m_sum <= '0;
            exp_wr <= 1'b0; exp_addr <= '0; exp_data <= '0;
        end else begin
            exp_wr <= 1'b0;
            if (start && !busy) begin
                m_cnt <= load_count; m_done <= '0; m_sum <= '0;
            end else if (in_valid && in_ready && m_done < m_cnt) begin
                exp_wr   <= 1'b1;
                exp_addr <= (32'(m_done) % 32'd16) * 32'd4;
                exp_data <= in_data;
                m_sum    <= m_sum + in_data;
                m_done   <= m_done + 5'd1;
            end
        end
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk32(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // One clock cycle, then the per-cycle model comparisons at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk1("wr_en", im_memWrite, exp_wr);
        if (exp_wr) begin
            chk32("wr_addr", im_addr, exp_addr);
            chk32("wr_data", im_dataIn, exp_data);
        end
        if (im_memWrite) begin
            wr_total++;
            last_addr = im_addr;
        end
        chk32("words", 32'(words_loaded), 32'(m_done));
        chk1("rd_eq_run", im_memRead, core_run);
        if (core_run && !im_memWrite) chk32("fetch_mux", im_addr, fetch_pc);
    endtask

    task automatic reset_checks(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_wr"}, im_memWrite, 1'b0);
        chk1({tag, "_rd"}, im_memRead, 1'b0);
        chk32({tag, "_addr"}, im_addr, 32'd0);
        chk32({tag, "_dataIn"}, im_dataIn, 32'd0);
        chk1({tag, "_run"}, core_run, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk32({tag, "_words"}, 32'(words_loaded), 32'd0);
        chk1({tag, "_csum_err"}, csum_err, 1'b0);
    endtask

    // mode: 0 continuous, 1 valid every other cycle, 2 random valid, 3 long stall then continuous.
    task automatic run_load(input logic [4:0] cnt, input int mode);
        int c;
        start = 1'b1; load_count = cnt; in_valid = 1'b0;
        step();
        start = 1'b0;
        c = 0;
        while (busy && c < 400) begin
            if (mode == 0)      in_valid = 1'b1;
            else if (mode == 1) in_valid = c[0];
            else if (mode == 2) in_valid = 1'($urandom_range(0, 1));
            else                in_valid = (c >= 20);
            in_data = (m_done == m_cnt) ? m_sum : $urandom;
            step();
            c++;
        end
        chk1("load_timeout", busy, 1'b0);
        in_valid = 1'b0;
    endtask

`ifdef IM_LOAD_CHECKSUM_EN
    task automatic csum_case(input logic [31:0] trailer, input logic exp_run, input logic exp_err);
        start = 1'b1; load_count = 5'd2; in_valid = 1'b0;
        step();
        start = 1'b0; in_valid = 1'b1; in_data = 32'd1;
        step();
        in_data = 32'd2;
        step();
        in_data = trailer;
        step();
        chk1("cs_check_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk1("cs_run", core_run, exp_run);
        chk1("cs_err", csum_err, exp_err);
        chk1("cs_busy", busy, 1'b0);
        chk32("cs_words", 32'(words_loaded), 32'd2);
    endtask
`endif

    typedef struct {
        logic [4:0]  cnt;
        int          mode;
        logic [4:0]  exp_words;
        logic [31:0] exp_last;
        int          exp_nwr;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        vecs[0] = '{5'd2,  0, 5'd2,  32'h04, 2};
        vecs[1] = '{5'd16, 1, 5'd16, 32'h3C, 16};
        vecs[2] = '{5'd1,  0, 5'd1,  32'h00, 1};
        vecs[3] = '{5'd5,  2, 5'd5,  32'h10, 5};
        vecs[4] = '{5'd0,  0, 5'd0,  32'h00, 0};
        vecs[5] = '{5'd3,  3, 5'd3,  32'h08, 3};

        reset = 1'b0; start = 1'b0; load_count = '0; in_valid = 1'b0; in_data = '0; fetch_pc = '0;
        #1 reset_checks("por");
        @(negedge clk);
        reset = 1'b1;
        step();

        // Two-word load with continuous valid; start held into LOAD must be ignored.
        fetch_pc = 32'h08; start = 1'b1; load_count = 5'd2; in_valid = 1'b1; in_data = 32'h4E6A0000;
        step();
        chk1("s1_busy", busy, 1'b1);
        chk1("s1_ready", in_ready, 1'b1);
        chk1("s1_nowr", im_memWrite, 1'b0);
        step();
        start = 1'b0;
        chk1("s1_wr0", im_memWrite, 1'b1);
        chk32("s1_addr0", im_addr, 32'h00);
        chk32("s1_data0", im_dataIn, 32'h4E6A0000);
        chk32("s1_words1", 32'(words_loaded), 32'd1);
        in_data = 32'h2A6B0000;
        step();
        chk1("s1_wr1", im_memWrite, 1'b1);
        chk32("s1_addr1", im_addr, 32'h04);
        chk32("s1_data1", im_dataIn, 32'h2A6B0000);
        chk1("s1_flush_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        step();
`ifndef IM_LOAD_CHECKSUM_EN
        chk1("s1_run", core_run, 1'b1);
        chk1("s1_busy_off", busy, 1'b0);
        chk32("s1_fetch", im_addr, 32'h08);
        chk1("s1_rd", im_memRead, 1'b1);
        chk32("s1_words2", 32'(words_loaded), 32'd2);

        // Zero-length restart from RUN.
        start = 1'b1; load_count = 5'd0;
        step();
        start = 1'b0;
        chk1("z_run", core_run, 1'b1);
        chk32("z_words", 32'(words_loaded), 32'd0);
        chk1("z_nowr", im_memWrite, 1'b0);
        step();
        chk1("z_nowr2", im_memWrite, 1'b0);
`else
        step();
        in_valid = 1'b1; in_data = 32'h4E6A0000 + 32'h2A6B0000;
        step();
        in_valid = 1'b0;
        chk1("s1_run", core_run, 1'b1);
        csum_case(32'd3, 1'b1, 1'b0);
        csum_case(32'd4, 1'b0, 1'b1);
        step();
        chk1("cs_err_hold", csum_err, 1'b1);
        run_load(5'd1, 0);
        chk1("cs_err_clr", csum_err, 1'b0);
`endif

        for (int i = 0; i < 6; i++) begin
            w0 = wr_total;
            run_load(vecs[i].cnt, vecs[i].mode);
            chk1("tbl_run", core_run, 1'b1);
            chk1("tbl_csum", csum_err, 1'b0);
            chk32("tbl_words", 32'(words_loaded), 32'(vecs[i].exp_words));
            chk32("tbl_nwr", 32'(wr_total - w0), 32'(vecs[i].exp_nwr));
            if (vecs[i].exp_nwr > 0) chk32("tbl_last_addr", last_addr, vecs[i].exp_last);
        end

        // Asynchronous reset after the 3rd of 8 transfers, away from any clock edge.
        start = 1'b1; load_count = 5'd8; in_valid = 1'b1; in_data = $urandom;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_data = $urandom;
            step();
        end
        chk32("mid_words3", 32'(words_loaded), 32'd3);
        #2 reset = 1'b0;
        #1 reset_checks("midload");
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        w0 = wr_total;
        run_load(5'd1, 0);
        chk32("post_rst_nwr", 32'(wr_total - w0), 32'd1);
        chk32("post_rst_addr", last_addr, 32'h00);
        chk1("post_rst_run", core_run, 1'b1);

        for (int r = 0; r < 20; r++) begin
            logic [4:0] n;
            n = 5'($urandom_range(1, 16));
            fetch_pc = $urandom & 32'hFFFF_FFFC;
            w0 = wr_total;
            run_load(n, 2);
            chk1("rnd_run", core_run, 1'b1);
            chk32("rnd_words", 32'(words_loaded), 32'(n));
            chk32("rnd_nwr", 32'(wr_total - w0), 32'(n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/im_load_ctrl.md
IM_LOAD_CTRL -- requirements
Module: im_load_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 Ports SHALL be, in order:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request to begin a load
- load_count  input  5  words to load, 0..16
- in_valid  input  1  in_data holds a word
- in_data  input  32  instruction word stream
- in_ready  output  1  block accepts in_data this cycle
- fetch_pc  input  32  core fetch address
- im_addr  output  32  instruction-memory address (pc port)
- im_dataIn  output  32  instruction-memory write data
- im_memWrite  output  1  instruction-memory write enable
- im_memRead  output  1  instruction-memory read enable
- core_run  output  1  core may fetch and execute
- busy  output  1  load in progress
- words_loaded  output  5  words written since last start
- csum_err  output  1  checksum mismatch flag (see Configuration)

Function
REQ-003 FSM states SHALL be IDLE, LOAD, FLUSH, CHECK and RUN; CHECK exists only when the macro is defined.
REQ-004 IDLE+start SHALL latch load_count and clear words_loaded and csum_err.
- If load_count=0, the next state SHALL be RUN (no writes).
- Otherwise the next state SHALL be LOAD.
REQ-005 RUN+start SHALL behave identically to IDLE+start; start in LOAD, FLUSH or CHECK SHALL be ignored.
REQ-006 in_ready SHALL be 1 only in LOAD and CHECK; a transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-007 A LOAD transfer SHALL register im_dataIn=in_data, im_addr={26'b0,idx[3:0],2'b00} (idx = words_loaded before increment) and im_memWrite=1 for exactly the following cycle, and SHALL increment words_loaded.
- A write is thus held stable across the falling edge at which the memory captures it.
REQ-008 im_memWrite SHALL be 0 in any cycle not following a LOAD transfer; back-to-back transfers give consecutive write cycles.
REQ-009 On the transfer making words_loaded equal the latched count, the FSM SHALL enter FLUSH, which issues the final write cycle and then goes to CHECK if the macro is defined, else RUN.
REQ-010 Load addresses SHALL wrap modulo 16; with load_count=16 the final write SHALL target address 0x3C.
REQ-011 im_addr SHALL equal fetch_pc only when state=RUN and im_memWrite=0, and the loader address otherwise.
- im_memRead SHALL equal core_run.
REQ-012 core_run SHALL be 1 only in RUN; busy SHALL be 1 in LOAD, FLUSH and CHECK.
REQ-013 in_valid=0 in LOAD SHALL stall indefinitely with no writes and no timeout.

Reset
REQ-014 reset=0 SHALL immediately force IDLE with im_memWrite=0, im_memRead=0, im_addr=0, im_dataIn=0, in_ready=0, core_run=0, busy=0, words_loaded=0, csum_err=0 and latched count=0, including mid-LOAD.
- Words already written SHALL remain in memory; the memory's own reset is separate.
REQ-015 Reset release SHALL take effect on the first rising clk edge with reset=1.

Configuration
REQ-016 With IM_LOAD_CHECKSUM_EN defined, the block SHALL accumulate a modulo-2^32 sum of the loaded words.
- In CHECK it SHALL accept one trailer word that is not written to memory.
- On a match it SHALL go to RUN; on a mismatch it SHALL set csum_err=1 and go to IDLE.
- csum_err SHALL hold until the next start or reset.
- A load_count=0 start SHALL skip CHECK.
REQ-017 Without IM_LOAD_CHECKSUM_EN, the CHECK state and the sum register SHALL be absent, csum_err SHALL be tied 0, and FLUSH SHALL go directly to RUN.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- start, load_count=2, words 0x4E6A0000 and 0x2A6B0000 with continuous in_valid -> writes at addresses 0x00 and 0x04 in consecutive cycles; core_run=1 two cycles after the last transfer; words_loaded=2.
- load_count=16, in_valid toggled every other cycle -> 16 writes to 0x00..0x3C in order, im_memWrite never high without a preceding transfer, final address 0x3C.
- reset=0 asserted after the 3rd of 8 transfers -> all outputs at reset values without waiting for a clock edge; a later start with load_count=1 writes address 0x00.
- With the macro defined: load_count=2, words 1 and 2, trailer 3 -> RUN with csum_err=0; trailer 4 -> IDLE with csum_err=1 and core_run=0.
- In RUN with fetch_pc=0x08 -> im_addr=0x08 and im_memRead=1; start with load_count=0 -> RUN with no im_memWrite pulse and words_loaded=0.
